// File: rtl/piano_pkg.sv
// Shared widths, the stored segment record and the recorder FSM states.
package piano_pkg;

  localparam int NOTE_W = 4;
  localparam int DUR_W  = 8;
  localparam int SEG_W  = 1 + NOTE_W + DUR_W;

  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } seg_t;

  typedef enum logic [1:0] {
    IDLE,
    RECORD,
    PLAY
  } state_t;

endpackage

// File: rtl/rec_buffer.sv
// Segment store: one register per entry, synchronous write, combinational read.
module rec_buffer
  import piano_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  seg_t              i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output seg_t              o_rd_data
);

  seg_t r_mem [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (i_wr_en && (i_wr_addr == ADDR_W'(gi))) begin
          r_mem[gi] <= i_wr_data;
        end
      end
    end
  endgenerate

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/key_recorder.sv
// Records {on, note, duration} segments from the keyboard and plays them back
// to the buzzer; durations are counted in TICK_DIV-cycle ticks, capped at 255.
module key_recorder
  import piano_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int DEPTH    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  input  logic [NOTE_W-1:0] key_in,
  input  logic              key_in_on,
  output logic [NOTE_W-1:0] key_out,
  output logic              key_out_on,
  output logic              recording,
  output logic              playing,
  output logic              full,
  output logic [5:0]        count
);

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             r_state, w_state_next;
  seg_t               r_seg, w_seg_next;
  logic [CNT_W-1:0]   r_tick_cnt;
  logic [5:0]         r_count, w_count_next;
  logic               r_full, w_full_next;
  logic [ADDR_W-1:0]  r_idx, w_idx_next;
  logic [DUR_W-1:0]   r_rem, w_rem_next;
  logic [NOTE_W-1:0]  r_key_out, w_key_out_next;
  logic               r_key_out_on, w_key_out_on_next;
  logic               r_recording, r_playing;

  logic               w_tick, w_tick_clr, w_wr_en, w_change;
  logic [NOTE_W-1:0]  w_in_note;
  logic [DUR_W-1:0]   w_dur_eff;
  logic [ADDR_W-1:0]  w_rd_addr;
  seg_t               w_wr_data, w_rd_data;

  assign w_tick    = (r_tick_cnt == CNT_W'(TICK_DIV - 1));
  assign w_in_note = key_in_on ? key_in : '0;
  assign w_change  = ({key_in_on, w_in_note} != {r_seg.on, r_seg.note});
  // A tick on the closing edge still belongs to the segment being closed.
  assign w_dur_eff = r_seg.dur + DUR_W'(w_tick);

  rec_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_count[ADDR_W-1:0]),
    .i_wr_data (w_wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_comb begin
    w_state_next      = r_state;
    w_seg_next        = r_seg;
    w_count_next      = r_count;
    w_full_next       = r_full;
    w_idx_next        = r_idx;
    w_rem_next        = r_rem;
    w_key_out_next    = r_key_out;
    w_key_out_on_next = r_key_out_on;
    w_tick_clr        = 1'b0;
    w_wr_en           = 1'b0;
    w_wr_data         = '{on: r_seg.on, note: r_seg.note, dur: w_dur_eff};
    w_rd_addr         = r_idx + ADDR_W'(1);
    case (r_state)
      IDLE: begin
        w_rd_addr = '0;
        if (stop) begin
          w_state_next = IDLE;
        end else if (rec_start) begin
          w_count_next = '0;
          w_full_next  = 1'b0;
          w_seg_next   = '{on: key_in_on, note: w_in_note, dur: '0};
          w_tick_clr   = 1'b1;
          w_state_next = RECORD;
        end else if (play_start && (r_count != '0)) begin
          w_idx_next        = '0;
          w_key_out_next    = w_rd_data.note;
          w_key_out_on_next = w_rd_data.on;
          w_rem_next        = w_rd_data.dur;
          w_tick_clr        = 1'b1;
          w_state_next      = PLAY;
        end
      end
      RECORD: begin
        w_seg_next.dur = w_dur_eff;
        if (stop || w_change || (w_dur_eff == '1)) begin
          w_seg_next = '{on: key_in_on, note: w_in_note, dur: '0};
          w_tick_clr = 1'b1;
          if (w_dur_eff != '0) begin
            w_wr_en      = 1'b1;
            w_count_next = r_count + 6'd1;
            if (w_count_next == 6'(DEPTH)) begin
              w_full_next  = 1'b1;
              w_state_next = IDLE;
            end
          end
          if (stop) begin
            w_state_next = IDLE;
          end
        end
      end
      PLAY: begin
        if (stop) begin
          w_key_out_next    = '0;
          w_key_out_on_next = 1'b0;
          w_state_next      = IDLE;
        end else if (w_tick) begin
          if (r_rem == DUR_W'(1)) begin
            if (6'(r_idx) == (r_count - 6'd1)) begin
              w_key_out_next    = '0;
              w_key_out_on_next = 1'b0;
              w_state_next      = IDLE;
            end else begin
              w_idx_next        = r_idx + ADDR_W'(1);
              w_key_out_next    = w_rd_data.note;
              w_key_out_on_next = w_rd_data.on;
              w_rem_next        = w_rd_data.dur;
              w_tick_clr        = 1'b1;
            end
          end else begin
            w_rem_next = r_rem - DUR_W'(1);
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_seg        <= '0;
      r_tick_cnt   <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_idx        <= '0;
      r_rem        <= '0;
      r_key_out    <= '0;
      r_key_out_on <= 1'b0;
      r_recording  <= 1'b0;
      r_playing    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_seg        <= w_seg_next;
      r_tick_cnt   <= (w_tick_clr || w_tick) ? '0 : r_tick_cnt + CNT_W'(1);
      r_count      <= w_count_next;
      r_full       <= w_full_next;
      r_idx        <= w_idx_next;
      r_rem        <= w_rem_next;
      r_key_out    <= w_key_out_next;
      r_key_out_on <= w_key_out_on_next;
      r_recording  <= (w_state_next == RECORD);
      r_playing    <= (w_state_next == PLAY);
    end
  end

  assign key_out    = r_key_out;
  assign key_out_on = r_key_out_on;
  assign recording  = r_recording;
  assign playing    = r_playing;
  assign full       = r_full;
  assign count      = r_count;

endmodule

// File: tb/tb_key_recorder.sv
// Self-checking bench: recorded segments are queued as expected playback runs
// and compared against the output runs observed during playback.
module tb_key_recorder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rec_start = 1'b0;
  logic       play_start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] key_in = '0;
  logic       key_in_on = 1'b0;
  logic [3:0] key_out;
  logic       key_out_on;
  logic       recording;
  logic       playing;
  logic       full;
  logic [5:0] count;

  int n_checks = 0;
  int n_fail = 0;
  int sb_q[$];

  key_recorder #(.TICK_DIV(4), .DEPTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rec_start  (rec_start),
    .play_start (play_start),
    .stop       (stop),
    .key_in     (key_in),
    .key_in_on  (key_in_on),
    .key_out    (key_out),
    .key_out_on (key_out_on),
    .recording  (recording),
    .playing    (playing),
    .full       (full),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pack_run(input logic on, input logic [3:0] note, input int len);
    return (int'(on) << 20) | (int'(note) << 16) | (len & 16'hFFFF);
  endfunction

  task automatic push_exp(input logic on, input logic [3:0] note, input int len);
    sb_q.push_back(pack_run(on, note, len));
  endtask

  task automatic rec_seg(input logic on, input logic [3:0] note, input int len, input logic first);
    key_in_on = on;
    key_in    = note;
    rec_start = first;
    for (int k = 0; k < len; k++) begin
      step();
      rec_start = 1'b0;
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic play_and_check(input int max_cycles);
    int cur, now, len, cyc, exp;
    bit done;
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    check("play_active", playing, 1);
    cur  = {key_out_on, key_out};
    len  = 1;
    cyc  = 0;
    done = 0;
    while (!done) begin
      step();
      cyc++;
      now = {key_out_on, key_out};
      if (!playing || now != cur) begin
        $display("run on=%0d note=%0d len=%0d", cur[4], cur[3:0], len);
        if (sb_q.size() == 0) begin
          check("sb_unexpected_run", pack_run(cur[4], cur[3:0], len), -1);
        end else begin
          exp = sb_q.pop_front();
          check("sb_run", pack_run(cur[4], cur[3:0], len), exp);
        end
        cur = now;
        len = 1;
        if (!playing) done = 1;
      end else begin
        len++;
      end
      if (!done && cyc > max_cycles) begin
        check("play_timeout", cyc, max_cycles);
        done = 1;
      end
    end
    check("play_end_out", {key_out_on, key_out}, 0);
    check("sb_left", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    // Reset state and ignored playback of an empty buffer
    repeat (3) step();
    rst = 1'b0;
    check("rst_key_out", {key_out_on, key_out}, 0);
    check("rst_flags", {recording, playing, full}, 0);
    check("rst_count", count, 0);
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    check("play_empty_ignored", playing, 0);

    // Three-segment recording; the off segment carries a stray note code
    rec_seg(1'b1, 4'd3, 40, 1'b1);
    check("rec_active", recording, 1);
    push_exp(1'b1, 4'd3, 40);
    rec_seg(1'b0, 4'd9, 20, 1'b0);
    push_exp(1'b0, 4'd0, 20);
    rec_seg(1'b1, 4'd7, 16, 1'b0);
    push_exp(1'b1, 4'd7, 16);
    do_stop();
    check("rec3_count", count, 3);
    check("rec3_idle", recording, 0);
    play_and_check(200);

    // Long hold splits at 255 ticks into two same-note entries
    rec_seg(1'b1, 4'd5, 1200, 1'b1);
    do_stop();
    check("long_count", count, 2);
    push_exp(1'b1, 4'd5, 1200);
    play_and_check(1400);

    // Overflow: writes beyond DEPTH are refused
    for (int i = 0; i < 40; i++) begin
      key_in_on = 1'b1;
      key_in    = 4'(i % 16);
      rec_start = (i == 0);
      for (int j = 0; j < 8; j++) begin
        step();
        rec_start = 1'b0;
        if (i == 31 && j == 7) check("ovf_still_rec", recording, 1);
        if (i == 32 && j == 0) begin
          check("ovf_rec_drop", recording, 0);
          check("ovf_full", full, 1);
        end
      end
      if (i < 32) push_exp(1'b1, 4'(i % 16), 8);
    end
    do_stop();
    check("ovf_count", count, 32);
    check("ovf_full_hold", full, 1);
    play_and_check(400);

    // Simultaneous rec_start and play_start: recording wins
    key_in_on  = 1'b1;
    key_in     = 4'd2;
    rec_start  = 1'b1;
    play_start = 1'b1;
    step();
    rec_start  = 1'b0;
    play_start = 1'b0;
    check("prio_rec", {recording, playing}, 2'b10);
    check("prio_clear", {full, count}, 0);
    repeat (11) step();
    rec_seg(1'b1, 4'd9, 8, 1'b0);
    rec_seg(1'b1, 4'd4, 8, 1'b0);
    do_stop();
    check("prio_count", count, 3);

    // Stop during entry 1 of playback
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    check("stop_entry0", {key_out_on, key_out}, 5'h12);
    repeat (12) step();
    check("stop_entry1", {key_out_on, key_out}, 5'h19);
    do_stop();
    check("stop_out", {key_out_on, key_out}, 0);
    check("stop_idle", playing, 0);
    check("stop_count", count, 3);

    // Asynchronous reset in the middle of playback
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    repeat (5) step();
    check("mid_play", playing, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_out", {key_out_on, key_out}, 0);
    check("arst_flags", {recording, playing, full}, 0);
    check("arst_count", count, 0);
    step();
    rst = 1'b0;
    step();
    check("arst_after", {playing, count}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_recorder.md
KEY_RECORDER -- requirements
Module: key_recorder

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, clk cycles per duration tick (10 ms at 100 MHz).
REQ-002 SHALL have parameter DEPTH, default 32, number of stored segments.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port rec_start  input  1  one-cycle pulse that starts recording.
REQ-006 SHALL have port play_start  input  1  one-cycle pulse that starts playback.
REQ-007 SHALL have port stop  input  1  one-cycle pulse that ends recording or playback.
REQ-008 SHALL have port key_in  input  4  note code from keyControl.
REQ-009 SHALL have port key_in_on  input  1  note-active flag from keyControl.
REQ-010 SHALL have port key_out  output  4  played-back note code, feeding the buzzer key input.
REQ-011 SHALL have port key_out_on  output  1  played-back note-active flag, feeding the buzzer key_on input.
REQ-012 SHALL have port recording  output  1  high in RECORD state.
REQ-013 SHALL have port playing  output  1  high in PLAY state.
REQ-014 SHALL have port full  output  1  buffer holds DEPTH segments.
REQ-015 SHALL have port count  output  6  number of stored segments.

Function
REQ-016 SHALL implement FSM states IDLE, RECORD, PLAY.
REQ-017 SHALL store each segment as {on, note[3:0], dur[7:0]}, with note forced to 0 when on=0.
REQ-018 SHALL use a tick counter counting 0..TICK_DIV-1 that emits a tick at TICK_DIV-1 and clears on every segment start.
REQ-019 IDLE: rec_start SHALL clear count and full, open a segment with the current inputs, and go to RECORD; play_start with count>0 SHALL go to PLAY; play_start with count=0 SHALL be ignored.
REQ-020 When rec_start and play_start arrive together in IDLE, rec_start SHALL win.
REQ-021 stop SHALL take priority over rec_start and play_start in every state; rec_start and play_start outside IDLE SHALL be ignored.
REQ-022 RECORD: each tick SHALL increment the open segment dur.
REQ-023 RECORD: a change in {key_in_on, key_in(when on)} SHALL close the open segment and open a new one with dur=0, on the same edge.
REQ-024 RECORD: dur reaching 255 SHALL close the segment, with a same-note segment continuing.
REQ-025 A closed segment with dur=0 SHALL be discarded; otherwise it SHALL be written at index count, and count SHALL increment.
REQ-026 RECORD: a write making count=DEPTH SHALL set full and force IDLE.
REQ-027 RECORD: stop SHALL close the open segment under the REQ-025 rules, then go to IDLE.
REQ-028 PLAY: on the edge that samples play_start, key_out/key_out_on SHALL present entry 0, and the outputs SHALL hold each entry for exactly dur ticks (dur*TICK_DIV clk).
REQ-029 PLAY: after each entry the next entry SHALL follow with no gap cycle.
REQ-030 PLAY: after the last entry (index count-1), key_out_on and key_out SHALL go to 0 and the FSM to IDLE on the same edge.
REQ-031 PLAY: stop SHALL zero key_out/key_out_on on the next edge and go to IDLE; buffer and count SHALL be retained.
REQ-032 Outside PLAY, key_out and key_out_on SHALL be 0.
REQ-033 recording and playing SHALL be registered and SHALL reflect state with no extra latency.

Reset
REQ-034 rst SHALL immediately force IDLE, key_out=0, key_out_on=0, recording=0, playing=0, full=0, count=0, and tick counter=0.
REQ-035 Buffer contents need not be reset; count=0 SHALL make them invalid.
REQ-036 Reset asserted mid-RECORD or mid-PLAY SHALL abort with no segment written.

Structure
REQ-037 Package piano_pkg SHALL hold NOTE_W=4, DUR_W=8, the segment record type, and the FSM state enum.
REQ-038 Sub-module rec_buffer SHALL provide DEPTH x 13 register storage with one synchronous write port and one combinational read port.
REQ-039 The FSM, tick divider and counters SHALL reside in key_recorder.

Verification (TICK_DIV=4)
REQ-040 Reset: assert rst mid-PLAY -> all outputs 0 within the same cycle, count=0.
REQ-041 Record: rec_start; note 3 on 10 ticks, off 5 ticks, note 7 on 4 ticks; stop -> count=3, entries (1,3,10),(0,0,5),(1,7,4).
REQ-042 Play: play_start after REQ-041 -> key_out=3/on=1 for 40 clk, on=0 for 20 clk, key_out=7/on=1 for 16 clk, then IDLE with playing=0.
REQ-043 Long hold: note 5 held 300 ticks then stop -> entries (1,5,255),(1,5,45), count=2.
REQ-044 Overflow: 40 note changes, 2 ticks each -> full=1, count=32, recording drops after the 32nd write, and the remaining changes are ignored.
REQ-045 Priority: simultaneous rec_start+play_start in IDLE -> RECORD; stop during PLAY at entry 1 -> key_out_on=0 next edge, count unchanged.
